cf_tmr_pwm_core_n: RTL
======================

Name: cf_tmr_pwm_core_n

Overview:
- Parametrised timer/PWM core: one W-bit up/down/up-down counter with prescaler, one-shot or periodic operation, and NCH compare channels.
- Each channel drives an event-programmable PWM pair with inversion, dead-time insertion and a common latched fault shutdown.
- Bus-agnostic: register state arrives as plain ports from the AHBL/APB/WB wrappers. The core replaces the fixed two-compare, single-pair timer.

Parameters:
- W, 32, counter/reload/compare width
- NCH, 4, compare channels = PWM pairs
- PW, 16, prescaler width
- DTW, 8, dead-time counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tmr_en  in  1  timer enable; a 0->1 transition (re)starts the counter
- restart  in  1  single-cycle pulse, reloads start value
- reload  in  W  top value
- prescaler  in  PW  tick every prescaler+1 clocks
- mode  in  2  01 down, 10 up, 11 up/down (00 treated as stopped)
- periodic  in  1  1 periodic, 0 one-shot
- cmp  in  NCH*W  compare values; channel k at [k*W +: W]
- pwm_cfg  in  NCH*8  per channel 4 actions x 2 bits: [1:0] zero, [3:2] cmp-up, [5:4] top, [7:6] cmp-down
- pwm_en  in  NCH  channel enable
- pwm_inv  in  NCH  invert channel
- dt_en  in  1  dead-time enable
- deadtime  in  DTW  dead time = deadtime+1 clocks
- fault  in  1  fault request
- fault_clr  in  1  fault clear pulse
- tmr  out  W  counter value
- dir  out  1  1 counting up
- to  out  1  timeout pulse
- match  out  NCH  compare-match pulses
- fault_lat  out  1  fault latched
- pwm_p  out  NCH  PWM outputs
- pwm_n  out  NCH  complementary outputs

Behaviour:
- Reset: tmr=0, dir=1, prescaler count=0, to/match=0, raw PWM=0, fault_lat=0, pwm_p=pwm_n=0, stopped=0.
- Prescaler: count 0..prescaler while tmr_en. tick when count==prescaler. prescaler=0 gives a tick every clock.
- Start (tmr_en rise or restart): up and up/down load 0 with dir=1; down loads reload with dir=0. Prescaler cleared; stopped cleared.
- Counter advances only on tick, and only when tmr_en=1 and !stopped.
- Up: if tmr>=reload then to=1; periodic -> tmr=0, else stopped. Otherwise tmr+1.
- Down: if tmr==0 then to=1; periodic -> tmr=reload, else stopped. Otherwise tmr-1.
- Up/down, dir=1: at tmr>=reload, tmr=reload-1 and dir=0. Otherwise tmr+1.
- Up/down, dir=0: at tmr==0, to=1; periodic -> tmr=1, dir=1, else stopped. Otherwise tmr-1.
- Up/down period is 2*reload ticks.
- reload=0 in any mode: tmr holds 0 and to fires every tick while periodic.
- Events are evaluated on tick against the pre-update tmr:
  - zero: tmr==0
  - top: tmr>=reload
  - cmp-up: tmr==cmp[k] and dir=1
  - cmp-down: tmr==cmp[k] and dir=0
- match[k] = cmp-up|cmp-down. to and match[k] are single-cycle pulses registered with the counter update.
- Action codes: 00 none, 01 clear, 10 set, 11 toggle.
- Coincident events apply by priority, highest first: cmp-down, top, cmp-up, zero. Only the highest non-00 action is applied.
- Raw PWM is forced to 0 while pwm_en[k]=0.
- x = raw ^ pwm_inv[k]. All outputs are registered, one clock after raw changes.
- dt_en=0: pwm_p=x, pwm_n=~x. A disabled channel outputs p=0 (before inv), n=1.
- dt_en=1: on any change of x, both outputs go 0 for deadtime+1 clocks, then the side matching x goes 1. A further change of x during the dead band restarts it.
- Fault: fault=1 sets fault_lat on the next edge; pwm_p/pwm_n are forced 0 while fault_lat=1.
- fault_clr clears fault_lat only when fault=0; with fault=1 it stays set. The counter keeps running during fault.
- tmr_en=0: tmr and raw PWM hold; prescaler cleared; no events.
- rst mid-operation overrides everything in the same edge.

Test Plan:
- Up/down: reload=10, prescaler=4, periodic. Required: tmr 0->10->0 repeating, each value held 5 clocks; to every 100 clocks; dir falls at 10.
- Up one-shot: reload=15, prescaler=2. Required: tmr counts 0..15 and holds 15; a single to pulse; restart pulse re-runs the sequence.
- Down periodic with reload changed mid-run: reload=15 then 5. Required: next wrap loads 5; to on every 0.
- PWM: up/down, reload=10, prescaler=1, cmp0=3, cfg0 set@cmp-up and clear@cmp-down. Required: pwm_p[0] high across tmr 3..10..3, duty 14/20 ticks; match[0] pulses twice per period.
- Dead time: as in the PWM scenario, plus dt_en=1, deadtime=1, pwm_inv[0]=1. Required: both outputs low for exactly 2 clocks at every edge; p/n never high together.
- Fault: assert fault 1 clock mid-PWM. Required: all outputs 0 next edge; fault_clr with fault=1 is ignored; fault_clr with fault=0 resumes outputs.

Source files
------------

// File: rtl/cf_tmr_pwm_core_n.sv
// Timer/PWM core: prescaled up/down/up-down counter whose compare events drive NCH dead-time PWM pairs.
// Events update on tick; outputs are registered one clock after raw PWM changes; there is no flow control.
module cf_tmr_pwm_core_n #(
    parameter int W   = 32,
    parameter int NCH = 4,
    parameter int PW  = 16,
    parameter int DTW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tmr_en,
    input  logic             restart,
    input  logic [W-1:0]     reload,
    input  logic [PW-1:0]    prescaler,
    input  logic [1:0]       mode,
    input  logic             periodic,
    input  logic [NCH*W-1:0] cmp,
    input  logic [NCH*8-1:0] pwm_cfg,
    input  logic [NCH-1:0]   pwm_en,
    input  logic [NCH-1:0]   pwm_inv,
    input  logic             dt_en,
    input  logic [DTW-1:0]   deadtime,
    input  logic             fault,
    input  logic             fault_clr,
    output logic [W-1:0]     tmr,
    output logic             dir,
    output logic             to,
    output logic [NCH-1:0]   match,
    output logic             fault_lat,
    output logic [NCH-1:0]   pwm_p,
    output logic [NCH-1:0]   pwm_n
);

    logic                    en_q, en_d;
    logic [PW-1:0]           psc_q, psc_d;
    logic [W-1:0]            tmr_q, tmr_d;
    logic                    dir_q, dir_d, stop_q, stop_d, to_q, to_d, flt_q, flt_d;
    logic [NCH-1:0]          match_q, match_d, raw_q, raw_d, xprev_q, xprev_d;
    logic [NCH-1:0]          p_q, p_d, n_q, n_d;
    logic [NCH-1:0][DTW-1:0] dtc_q, dtc_d;
    logic                    start, tick, adv, at_top, at_zero;
    logic [NCH-1:0]          x, eq;
    logic [NCH-1:0][1:0]     act;

    assign start   = (tmr_en & ~en_q) | restart;
    assign tick    = tmr_en & (psc_q == prescaler);
    assign adv     = tick & ~start & ~stop_q & (mode != 2'b00);
    assign at_top  = tmr_q >= reload;
    assign at_zero = tmr_q == '0;
    assign x       = raw_q ^ pwm_inv;

    always_comb begin
        en_d   = tmr_en;
        psc_d  = psc_q;
        tmr_d  = tmr_q;
        dir_d  = dir_q;
        stop_d = stop_q;
        to_d   = 1'b0;
        if (start) begin
            psc_d  = '0;
            stop_d = 1'b0;
            if (mode == 2'b01) begin
                tmr_d = reload;
                dir_d = 1'b0;
            end else begin
                tmr_d = '0;
                dir_d = 1'b1;
            end
        end else if (!tmr_en) begin
            psc_d = '0;
        end else begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (adv) begin
                case (mode)
                    2'b10: begin
                        if (at_top) begin
                            to_d = 1'b1;
                            if (periodic) tmr_d = '0;
                            else          stop_d = 1'b1;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                    2'b01: begin
                        if (at_zero) begin
                            to_d = 1'b1;
                            if (periodic) tmr_d = reload;
                            else          stop_d = 1'b1;
                        end else begin
                            tmr_d = tmr_q - 1'b1;
                        end
                    end
                    default: begin
                        // A zero reload pins the counter at 0 rather than turning around.
                        if (reload == '0 && at_zero) begin
                            to_d   = 1'b1;
                            stop_d = ~periodic;
                        end else if (dir_q) begin
                            if (at_top) begin
                                tmr_d = reload - 1'b1;
                                dir_d = 1'b0;
                            end else begin
                                tmr_d = tmr_q + 1'b1;
                            end
                        end else if (at_zero) begin
                            to_d = 1'b1;
                            if (periodic) begin
                                tmr_d = W'(1);
                                dir_d = 1'b1;
                            end else begin
                                stop_d = 1'b1;
                            end
                        end else begin
                            tmr_d = tmr_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Lower-priority events are written first so the highest non-zero action wins.
    always_comb begin
        eq      = '0;
        act     = '0;
        match_d = '0;
        raw_d   = raw_q;
        for (int k = 0; k < NCH; k++) begin
            eq[k] = tmr_q == cmp[k*W +: W];
            if (at_zero && pwm_cfg[k*8 +: 2] != 2'b00)            act[k] = pwm_cfg[k*8 +: 2];
            if (eq[k] && dir_q && pwm_cfg[k*8+2 +: 2] != 2'b00)   act[k] = pwm_cfg[k*8+2 +: 2];
            if (at_top && pwm_cfg[k*8+4 +: 2] != 2'b00)           act[k] = pwm_cfg[k*8+4 +: 2];
            if (eq[k] && !dir_q && pwm_cfg[k*8+6 +: 2] != 2'b00)  act[k] = pwm_cfg[k*8+6 +: 2];
            match_d[k] = adv & eq[k];
            if (adv) begin
                case (act[k])
                    2'b01:   raw_d[k] = 1'b0;
                    2'b10:   raw_d[k] = 1'b1;
                    2'b11:   raw_d[k] = ~raw_q[k];
                    default: raw_d[k] = raw_q[k];
                endcase
            end
            if (!pwm_en[k]) raw_d[k] = 1'b0;
        end
    end

    // Dead band runs even with dt_en=0 so enabling it mid-run starts from a consistent state.
    always_comb begin
        flt_d   = fault | (flt_q & ~fault_clr);
        xprev_d = x;
        dtc_d   = dtc_q;
        p_d     = '0;
        n_d     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (x[k] != xprev_q[k])     dtc_d[k] = deadtime;
            else if (dtc_q[k] != '0)    dtc_d[k] = dtc_q[k] - 1'b1;
            if (!dt_en || (x[k] == xprev_q[k] && dtc_q[k] == '0)) begin
                p_d[k] = x[k];
                n_d[k] = ~x[k];
            end
            if (flt_d) begin
                p_d[k] = 1'b0;
                n_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            psc_q   <= '0;
            tmr_q   <= '0;
            dir_q   <= 1'b1;
            stop_q  <= 1'b0;
            to_q    <= 1'b0;
            match_q <= '0;
            raw_q   <= '0;
            flt_q   <= 1'b0;
            xprev_q <= '0;
            dtc_q   <= '0;
            p_q     <= '0;
            n_q     <= '0;
        end else begin
            en_q    <= en_d;
            psc_q   <= psc_d;
            tmr_q   <= tmr_d;
            dir_q   <= dir_d;
            stop_q  <= stop_d;
            to_q    <= to_d;
            match_q <= match_d;
            raw_q   <= raw_d;
            flt_q   <= flt_d;
            xprev_q <= xprev_d;
            dtc_q   <= dtc_d;
            p_q     <= p_d;
            n_q     <= n_d;
        end
    end

    assign tmr       = tmr_q;
    assign dir       = dir_q;
    assign to        = to_q;
    assign match     = match_q;
    assign fault_lat = flt_q;
    assign pwm_p     = p_q;
    assign pwm_n     = n_q;

endmodule
